addr_merge: RTL

ADDR_MERGE -- requirements
Module: addr_merge

---
 rtl/addr_merge.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/addr_merge.sv
`default_nettype none
// ============================================================================
// addr_merge : two range-checked channel FIFOs merged onto one output register
//              with round-robin arbitration and sticky drop flags.
// Revision   : 1.0
// ============================================================================
module addr_merge #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_a,
    input  logic [7:0]  addr_a,
    input  logic [15:0] data_a,
    input  logic        valid_b,
    input  logic [7:0]  addr_b,
    input  logic [15:0] data_b,
    input  logic        out_ready,
    output logic        valid_out,
    output logic [7:0]  addr_out,
    output logic [15:0] data_out,
    output logic        src_out,
    output logic        full_a,
    output logic        full_b,
    output logic        ovf_a,
    output logic        ovf_b,
    output logic        err_a,
    output logic        err_b
);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [1:0]       w_valid;
    logic [1:0]       w_in_range;
    logic [1:0]       w_full;
    logic [1:0]       w_nonempty;
    logic [1:0]       w_pop;
    logic [1:0]       w_ovf;
    logic [1:0]       w_err;
    logic [1:0][23:0] w_beat;
    logic [1:0][23:0] w_head;
    logic             w_load;
    logic             w_grant_b;
    logic             r_valid_out;
    logic             r_src_out;
    logic             r_rr_b;
    logic [23:0]      r_beat_out;

    assign w_valid    = {valid_b, valid_a};
    assign w_in_range = {(addr_b >= 8'h40), (addr_a < 8'h40)};
    assign w_beat[0]  = {addr_a, data_a};
    assign w_beat[1]  = {addr_b, data_b};

    // Index 0 is channel A, index 1 is channel B.
    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [23:0]        r_mem [DEPTH];
        logic [c_ptr_w-1:0] r_wr_ptr;
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [c_cnt_w-1:0] r_count;
        logic               r_ovf;
        logic               r_err;
        logic               w_push;

        // Full is judged on the registered count, so a same-edge pop never frees a slot.
        assign w_full[i]     = (r_count == c_full);
        assign w_nonempty[i] = (r_count != '0);
        assign w_push        = w_valid[i] && w_in_range[i] && !w_full[i];
        assign w_head[i]     = r_mem[r_rd_ptr];
        assign w_ovf[i]      = r_ovf;
        assign w_err[i]      = r_err;

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_beat[i];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop[i]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_valid[i] && !w_in_range[i]) begin
                    r_err <= 1'b1;
                end
                if (w_valid[i] && w_in_range[i] && w_full[i]) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_load    = (!r_valid_out || out_ready) && (|w_nonempty);
        w_grant_b = w_nonempty[1] && (!w_nonempty[0] || r_rr_b);
        w_pop     = '0;
        if (w_load) begin
            w_pop[w_grant_b] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            r_src_out   <= 1'b0;
            r_beat_out  <= '0;
            r_rr_b      <= 1'b0;
        end else if (w_load) begin
            r_valid_out <= 1'b1;
            r_src_out   <= w_grant_b;
            r_beat_out  <= w_head[w_grant_b];
            // The pointer only moves when a real choice between channels was made.
            if (&w_nonempty) begin
                r_rr_b <= !w_grant_b;
            end
        end else if (out_ready) begin
            r_valid_out <= 1'b0;
        end
    end

    assign valid_out            = r_valid_out;
    assign {addr_out, data_out} = r_beat_out;
    assign src_out              = r_src_out;
    assign full_a               = w_full[0];
    assign full_b               = w_full[1];
    assign ovf_a                = w_ovf[0];
    assign ovf_b                = w_ovf[1];
    assign err_a                = w_err[0];
    assign err_b                = w_err[1];

endmodule
`default_nettype wire
